// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bist_pkg
//  Purpose  : Shared types, default polynomials and next-state helpers for the
//             BIST pattern driver (LFSR generator and MISR compactor).
//  Revision : 1.0 - initial release
// ============================================================================
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [34:0] C_LFSR_POLY = 35'h5_0000_0000;  // taps 35,33
  localparam logic [23:0] C_MISR_POLY = 24'hE1_0000;      // taps 24,23,22,17
  localparam logic [34:0] C_SEED      = 35'h1;

  // Keeps the low w bits of a 64-bit working value.
  function automatic logic [63:0] width_mask(input int w);
    return {64{1'b1}} >> (64 - w);
  endfunction

  // Fibonacci shift: new LSB is the parity of the tapped bits.
  function automatic logic [63:0] lfsr_step(input logic [63:0] v,
                                            input logic [63:0] poly,
                                            input int          w);
    return {v[62:0], ^(v & poly)} & width_mask(w);
  endfunction

  // Galois shift with the outgoing MSB folding the polynomial back in,
  // plus a parallel data input XORed into every stage.
  function automatic logic [63:0] misr_step(input logic [63:0] v,
                                            input logic [63:0] poly,
                                            input logic [63:0] din,
                                            input int          w);
    logic msb;
    msb = |(v & (64'd1 << (w - 1)));
    return ({v[62:0], 1'b0} ^ (msb ? poly : 64'd0) ^ din) & width_mask(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bist_pattern_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : bist_pattern_driver_if
//  Purpose  : Control, status and CUT-facing signal bundle of the BIST driver.
//  Revision : 1.0 - initial release
// ============================================================================
interface bist_pattern_driver_if #(
  parameter int IN_W  = 35,
  parameter int OUT_W = 24
);
  logic             START;
  logic             HOLD;
  logic [OUT_W-1:0] GOLDEN;
  logic [OUT_W-1:0] CUT_OUT;
  logic [IN_W-1:0]  CUT_IN;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [OUT_W-1:0] SIGNATURE;

  // Controller / CUT side: drives commands and CUT responses.
  modport master (
    output START, HOLD, GOLDEN, CUT_OUT,
    input  CUT_IN, BUSY, DONE, PASS, SIGNATURE
  );

  // BIST driver side.
  modport slave (
    input  START, HOLD, GOLDEN, CUT_OUT,
    output CUT_IN, BUSY, DONE, PASS, SIGNATURE
  );
endinterface
`default_nettype wire

// File: rtl/bist_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : bist_lfsr
//  Purpose  : Generic shift register used both as Fibonacci pattern generator
//             and as Galois multiple-input signature register.
//  Revision : 1.0 - initial release
// ============================================================================
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int           W      = 4,
  parameter logic [W-1:0] POLY   = '0,
  parameter logic [W-1:0] SEED   = '0,
  parameter bit           GALOIS = 1'b0
) (
  input  wire          clk,
  input  wire          rst_n,
  input  wire          i_load,
  input  wire          i_en,
  input  wire  [W-1:0] i_din,
  output logic [W-1:0] o_q
);

  // An all-zero Fibonacci state would lock up, so a zero seed becomes 1;
  // a signature register legitimately starts from zero.
  localparam logic [W-1:0] C_INIT = (!GALOIS && (SEED == '0)) ? W'(1) : SEED;

  logic [W-1:0] r_q;
  logic [W-1:0] w_next;

  generate
    if (GALOIS) begin : g_galois
      assign w_next = W'(misr_step(64'(r_q), 64'(POLY), 64'(i_din), W));
    end else begin : g_fibonacci
      assign w_next = W'(lfsr_step(64'(r_q), 64'(POLY), W)) ^ i_din;
    end
  endgenerate

  // State register: reset/reload to the initial value, otherwise advance when enabled.
  always_ff @(posedge clk) begin
    if (!rst_n || i_load) begin
      r_q <= C_INIT;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/bist_pattern_driver.sv
`default_nettype none
// ============================================================================
//  Module   : bist_pattern_driver
//  Purpose  : Drives pseudo-random vectors into a circuit-under-test, compacts
//             its responses into a MISR signature and compares the result
//             against a golden value at the end of a run.
//  Revision : 1.0 - initial release
// ============================================================================
module bist_pattern_driver
  import bist_pkg::*;
#(
  parameter int               IN_W      = 35,
  parameter int               OUT_W     = 24,
  parameter int               NPAT      = 256,
  parameter int               CNT_W     = 16,
  parameter logic [IN_W-1:0]  LFSR_POLY = IN_W'(C_LFSR_POLY),
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(C_MISR_POLY),
  parameter logic [IN_W-1:0]  SEED      = IN_W'(C_SEED)
) (
  input wire                   CK,
  input wire                   RSTN,
  bist_pattern_driver_if.slave bus
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NPAT - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic             w_load, w_step;
  logic [IN_W-1:0]  w_lfsr;
  logic [OUT_W-1:0] w_misr;
  logic [OUT_W-1:0] w_misr_nxt;

  // Signature the MISR would hold after absorbing the current response;
  // on the last pattern this is what gets judged against GOLDEN.
  assign w_misr_nxt = OUT_W'(misr_step(64'(w_misr), 64'(MISR_POLY),
                                       64'(bus.CUT_OUT), OUT_W));

  bist_lfsr #(
    .W      (IN_W),
    .POLY   (LFSR_POLY),
    .SEED   (SEED),
    .GALOIS (1'b0)
  ) u_gen (
    .clk    (CK),
    .rst_n  (RSTN),
    .i_load (w_load),
    .i_en   (w_step),
    .i_din  ({IN_W{1'b0}}),
    .o_q    (w_lfsr)
  );

  bist_lfsr #(
    .W      (OUT_W),
    .POLY   (MISR_POLY),
    .SEED   ({OUT_W{1'b0}}),
    .GALOIS (1'b1)
  ) u_misr (
    .clk    (CK),
    .rst_n  (RSTN),
    .i_load (w_load),
    .i_en   (w_step),
    .i_din  (bus.CUT_OUT),
    .o_q    (w_misr)
  );

  // Control state, pattern counter and verdict flags.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // Next-state decode: START reloads from IDLE/DONE, RUN advances unless held.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.START) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.HOLD) begin
          w_step    = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_misr_nxt == bus.GOLDEN);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.CUT_IN    = w_lfsr;
  assign bus.SIGNATURE = w_misr;
  assign bus.BUSY      = (r_state == ST_RUN);
  assign bus.DONE      = r_done;
  assign bus.PASS      = r_pass;

endmodule
`default_nettype wire
